// File: rtl/indicator_flash_controller.sv
// Turn-indicator sequencer: arbitrates hazard, held lever and comfort-tap requests
// and drives registered left/right lamps with a fixed 50% duty blink cadence.
module indicator_flash_controller #(
  parameter int HALF_PERIOD     = 8,
  parameter int COMFORT_FLASHES = 3,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hazard_req,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       tap_left,
  input  logic       tap_right,
  output logic       left_lamp,
  output logic       right_lamp,
  output logic [2:0] mode,
  output logic       comfort_done
);

  localparam int FCNT_W = (COMFORT_FLASHES < 2) ? 1 : $clog2(COMFORT_FLASHES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEFT   = 3'd1,
    S_RIGHT  = 3'd2,
    S_HAZARD = 3'd3,
    S_COMF_L = 3'd4,
    S_COMF_R = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              left_lamp_q, left_lamp_d;
  logic              right_lamp_q, right_lamp_d;
  logic              done_q, done_d;

  logic tap_l_v, tap_r_v, wrap, in_comf, comf_end, retap;

  always_comb begin
    // Simultaneous taps cancel each other out.
    tap_l_v  = tap_left & ~tap_right;
    tap_r_v  = tap_right & ~tap_left;
    wrap     = (cnt_q == CNT_W'(HALF_PERIOD - 1));
    in_comf  = (state_q == S_COMF_L) || (state_q == S_COMF_R);
    comf_end = in_comf && wrap && !phase_q && (fcnt_q == FCNT_W'(COMFORT_FLASHES - 1));
    retap    = ((state_q == S_COMF_L) && tap_l_v) || ((state_q == S_COMF_R) && tap_r_v);

    if (hazard_req || (left_req && right_req)) state_d = S_HAZARD;
    else if (left_req)                         state_d = S_LEFT;
    else if (right_req)                        state_d = S_RIGHT;
    else if (tap_l_v)                          state_d = S_COMF_L;
    else if (tap_r_v)                          state_d = S_COMF_R;
    else if (in_comf && !comf_end)             state_d = state_q;
    else                                       state_d = S_IDLE;

    cnt_d   = '0;
    phase_d = 1'b1;
    fcnt_d  = '0;
    if ((state_d != S_IDLE) && (state_d == state_q)) begin
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      phase_d = wrap ? ~phase_q : phase_q;
      fcnt_d  = fcnt_q;
      if (in_comf && wrap && !phase_q) fcnt_d = fcnt_q + 1'b1;
      // A same-side re-tap extends the sequence without disturbing the cadence.
      if (retap) fcnt_d = '0;
    end

    left_lamp_d  = phase_d && ((state_d == S_LEFT) || (state_d == S_COMF_L) || (state_d == S_HAZARD));
    right_lamp_d = phase_d && ((state_d == S_RIGHT) || (state_d == S_COMF_R) || (state_d == S_HAZARD));
    done_d       = comf_end && (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      phase_q      <= 1'b1;
      fcnt_q       <= '0;
      left_lamp_q  <= 1'b0;
      right_lamp_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      fcnt_q       <= fcnt_d;
      left_lamp_q  <= left_lamp_d;
      right_lamp_q <= right_lamp_d;
      done_q       <= done_d;
    end
  end

  assign left_lamp    = left_lamp_q;
  assign right_lamp   = right_lamp_q;
  assign mode         = state_q;
  assign comfort_done = done_q;

endmodule

// File: doc/indicator_flash_controller.md
# indicator_flash_controller

Sequencer for the car's turn-indicator lamps. It takes the driver's requests (held lever left/right, comfort tap left/right, hazard switch) and arbitrates between them. It generates the blink cadence with an internal half-period counter and drives the registered left/right lamp outputs. It sits between the switch-debounce logic and the lamp drivers, and replaces static indicator levels with a timed flash sequence.

## Interface
- HALF_PERIOD, 8: clock cycles per ON half and per OFF half of a flash; must be ≥ 2.
- COMFORT_FLASHES, 3: number of complete flashes (ON+OFF) produced by one comfort tap; must be ≥ 1.
- CNT_W, 8: width of the half-period counter; 2^CNT_W ≥ HALF_PERIOD.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- hazard_req  input  1  hazard switch level (debounced).
- left_req  input  1  lever held left, level.
- right_req  input  1  lever held right, level.
- tap_left  input  1  comfort tap left, single-cycle pulse.
- tap_right  input  1  comfort tap right, single-cycle pulse.
- left_lamp  output  1  left lamp drive, registered.
- right_lamp  output  1  right lamp drive, registered.
- mode  output  3  current state: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD, 4 COMF_L, 5 COMF_R.
- comfort_done  output  1  one-cycle pulse when a comfort sequence completes naturally.

## Operation
- States: IDLE, LEFT, RIGHT, HAZARD, COMF_L, COMF_R. Single registered FSM, with a half-period counter (cnt), a phase bit (1 = ON) and a flash counter (fcnt).
- Priority is evaluated every cycle, highest first:
  - hazard_req → HAZARD.
  - left_req && right_req → HAZARD (fail-safe).
  - left_req → LEFT.
  - right_req → RIGHT.
  - tap pulse → COMF_L or COMF_R.
  - An active comfort sequence continues.
  - Otherwise IDLE.
- tap_left && tap_right in the same cycle → ignored (treated as no tap).
- A tap arriving while hazard_req or a held lever is active → ignored; it is not queued.
- Entering any active state from a different state: cnt=0, phase=ON, fcnt=0.
- Staying in the same state: cnt increments. When cnt reaches HALF_PERIOD-1, cnt wraps to 0 and phase toggles.
- Lamps:
  - LEFT/COMF_L: left_lamp = phase, right_lamp = 0.
  - RIGHT/COMF_R: left_lamp = 0, right_lamp = phase.
  - HAZARD: both lamps = phase.
  - IDLE: both 0.
- Comfort sequences:
  - fcnt increments on each OFF→ON phase toggle.
  - At the wrap that ends the OFF half of flash COMFORT_FLASHES, the next state is IDLE and comfort_done pulses.
- Re-tap in the same direction during comfort: fcnt reloads to 0; cnt and phase continue undisturbed.
- Tap in the opposite direction during comfort: switch to the other comfort state with a full restart (phase ON, fcnt 0).
- Held request released (e.g. LEFT and left_req drops, no other request): → IDLE, lamps off on that edge.
- Hazard released: return to whichever lower-priority request is active, otherwise IDLE. An interrupted comfort sequence is not resumed.
- LEFT↔RIGHT direct change: counts as a state change, so the new side restarts with its ON phase.

## Timing
- Inputs are sampled at rising edge k. State, cnt, phase, lamps and mode all update at edge k, so lamps reflect a request one clock after it is asserted. No combinational path from input to output.
- Blink period: 2·HALF_PERIOD cycles with 50% duty. The first ON half is a full HALF_PERIOD cycles.
- Comfort sequence duration from the tap edge to IDLE: 2·HALF_PERIOD·COMFORT_FLASHES cycles.
- comfort_done is high for exactly the cycle following the edge that enters IDLE from COMF_x. It is not asserted when comfort is pre-empted.
- Reset (any time, including mid-flash): mode=IDLE, left_lamp=0, right_lamp=0, comfort_done=0, cnt=0, phase=ON, fcnt=0. These take effect immediately and asynchronously.
- After rst deasserts: the first edge evaluates requests normally.

## Test plan
- Reset mid-HAZARD flash → all outputs 0 asynchronously. Deassert rst with all requests 0 → mode stays 0.
- HALF_PERIOD=4: hold left_req from edge 1 → left_lamp pattern 1111 0000 1111…, right_lamp 0 throughout. Drop left_req → lamps 0 on the next edge, mode=0.
- COMFORT_FLASHES=3, HALF_PERIOD=4: tap_left pulse → left_lamp gives 3 ON pulses of 4 cycles each. mode returns to 0 after 24 cycles. comfort_done is high for 1 cycle.
- Held left_req, then hazard_req asserted → mode=3, both lamps restart ON together. Release hazard_req → mode=1 with the left phase restarted ON.
- left_req && right_req together → mode=3 and both lamps flash. tap_left && tap_right in the same cycle from IDLE → stays mode 0.
- During COMF_L, tap_right → mode=5, right_lamp ON immediately, 3 full flashes. During COMF_R, tap_right after 2 flashes → 3 further flashes with the phase uninterrupted.
